// File: rtl/mash111_dsm.sv
// Third-order MASH 1-1-1 delta-sigma modulator for a fractional-N divider.
// A shadow register holds the fractional word. Three cascaded first-order
// accumulators produce carries, and a noise-cancel network combines them
// into a small signed divider offset on every enabled reference-clock cycle.
// Optional build macro MASH_DITHER_EN adds a 15-bit LFSR whose LSB is the
// carry-in of the first accumulator.
module mash111_dsm #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] frac_in,
  input  logic             frac_ld,
  output logic [OUT_W-1:0] div_ofs,
  output logic             ofs_valid,
  output logic [WIDTH-1:0] frac_q
);

  logic [WIDTH-1:0] acc1_q, acc2_q, acc3_q;
  logic             c1_q, c2_q, c3_q;
  logic             c2_dq, c3_dq, c3_ddq;
  logic [WIDTH:0]   sum1, sum2, sum3;
  logic [OUT_W-1:0] y;
  logic             cin;

`ifdef MASH_DITHER_EN
  logic [14:0] lfsr_q;

  // Fibonacci LFSR x^15 + x^14 + 1; it advances only with the modulator
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 15'h1;
    end else if (en) begin
      lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  // Cascade sums; each stage adds the wrapped next value of the stage before
  always_comb begin
    sum1 = {1'b0, acc1_q} + {1'b0, frac_q} + {{WIDTH{1'b0}}, cin};
    sum2 = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};
    sum3 = {1'b0, acc3_q} + {1'b0, sum2[WIDTH-1:0]};
  end

  // Noise cancel: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3; modulo arithmetic gives two's complement
  always_comb begin
    y = OUT_W'(c1_q) + OUT_W'(c2_q) - OUT_W'(c2_dq) + OUT_W'(c3_q)
        - (OUT_W'(c3_dq) << 1) + OUT_W'(c3_ddq);
  end

  // Shadow fractional word; loads independently of en
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q <= '0;
    end else if (frac_ld) begin
      frac_q <= frac_in;
    end
  end

  // Accumulators, registered carries, carry delay line and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      c3_q    <= 1'b0;
      c2_dq   <= 1'b0;
      c3_dq   <= 1'b0;
      c3_ddq  <= 1'b0;
      div_ofs <= '0;
    end else if (en) begin
      acc1_q  <= sum1[WIDTH-1:0];
      acc2_q  <= sum2[WIDTH-1:0];
      acc3_q  <= sum3[WIDTH-1:0];
      c1_q    <= sum1[WIDTH];
      c2_q    <= sum2[WIDTH];
      c3_q    <= sum3[WIDTH];
      c2_dq   <= c2_q;
      c3_dq   <= c3_q;
      c3_ddq  <= c3_dq;
      div_ofs <= y;
    end
  end

  // Valid drops on a load and returns after the next enabled step
  always_ff @(posedge clk) begin
    if (rst) begin
      ofs_valid <= 1'b0;
    end else if (frac_ld) begin
      ofs_valid <= 1'b0;
    end else if (en) begin
      ofs_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mash111_dsm.sv
// Directed self-checking bench for mash111_dsm.
module tb_mash111_dsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] frac_in;
  logic       frac_ld;
  logic [3:0] div_ofs;
  logic       ofs_valid;
  logic [8:0] frac_q;

  int n_cmp = 0;
  int n_bad = 0;
  int run_a[80];

  mash111_dsm #(
    .WIDTH(9),
    .OUT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .frac_in  (frac_in),
    .frac_ld  (frac_ld),
    .div_ofs  (div_ofs),
    .ofs_valid(ofs_valid),
    .frac_q   (frac_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; frac_ld = 1'b0; frac_in = 9'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_idle(input logic [8:0] v);
    frac_in = v; frac_ld = 1'b1; en = 1'b0;
    tick();
    frac_ld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (div_ofs !== 4'd0) begin
      n_bad++; $display("FAIL reset_div_ofs got %h want 0", div_ofs);
    end
    n_cmp++;
    if (ofs_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ofs_valid got %b want 0", ofs_valid);
    end
    n_cmp++;
    if (frac_q !== 9'd0) begin
      n_bad++; $display("FAIL reset_frac_q got %0d want 0", frac_q);
    end
  endtask

  task automatic test_zero();
    int bad;
    bad = 0;
    en = 1'b1;
    tick();
    n_cmp++;
    if (ofs_valid !== 1'b1) begin
      n_bad++; $display("FAIL zero_first_valid got %b want 1", ofs_valid);
    end
    for (int i = 1; i < 1000; i++) begin
      tick();
      if (div_ofs !== 4'd0 || ofs_valid !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL zero_run bad_cycles got %0d want 0", bad);
    end
    en = 1'b0;
  endtask

  task automatic test_half();
    int exp_v[9] = '{0, 0, 2, -1, 1, 0, 2, -1, 1};
    int got, sum, bad;
    sum = 0; bad = 0;
    load_idle(9'd256);
    n_cmp++;
    if (frac_q !== 9'd256) begin
      n_bad++; $display("FAIL half_load_frac_q got %0d want 256", frac_q);
    end
    n_cmp++;
    if (ofs_valid !== 1'b0) begin
      n_bad++; $display("FAIL half_load_valid got %b want 0", ofs_valid);
    end
    en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      got = $signed(div_ofs);
      if (i < 9) begin
        n_cmp++;
        if (got !== exp_v[i]) begin
          n_bad++; $display("FAIL half_seq[%0d] got %0d want %0d", i, got, exp_v[i]);
        end
      end
      if (i == 0) begin
        n_cmp++;
        if (ofs_valid !== 1'b1) begin
          n_bad++; $display("FAIL half_valid got %b want 1", ofs_valid);
        end
      end
      if (got < -3 || got > 4) bad++;
      sum += got;
    end
    n_cmp++;
    if (sum < 253 || sum > 259) begin
      n_bad++; $display("FAIL half_sum got %0d want 256+-3", sum);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL half_range bad got %0d want 0", bad);
    end
    en = 1'b0;
  endtask

  task automatic test_ld_en_same();
    int exp_v[4] = '{0, 1, 0, 1};
    int got;
    do_reset();
    load_idle(9'd100);
    frac_in = 9'd300; frac_ld = 1'b1; en = 1'b1;
    tick();
    frac_ld = 1'b0;
    n_cmp++;
    if (frac_q !== 9'd300) begin
      n_bad++; $display("FAIL ldsame_frac_q got %0d want 300", frac_q);
    end
    n_cmp++;
    if (ofs_valid !== 1'b0) begin
      n_bad++; $display("FAIL ldsame_valid_cleared got %b want 0", ofs_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      got = $signed(div_ofs);
      n_cmp++;
      if (got !== exp_v[i]) begin
        n_bad++; $display("FAIL ldsame_seq[%0d] got %0d want %0d", i, got, exp_v[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (ofs_valid !== 1'b1) begin
          n_bad++; $display("FAIL ldsame_valid got %b want 1", ofs_valid);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_frac_one();
    int got, want, sum, bad;
    sum = 0; bad = 0;
    do_reset();
    load_idle(9'd1);
    en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      tick();
      got = $signed(div_ofs);
      if (i < 17) begin
        want = (i == 14) ? 1 : (i == 15) ? -2 : (i == 16) ? 1 : 0;
        n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL one_seq[%0d] got %0d want %0d", i, got, want);
        end
      end
      if (i < 512) sum += got;
      if (got < -3 || got > 4) bad++;
    end
    n_cmp++;
    if (sum < -2 || sum > 4) begin
      n_bad++; $display("FAIL one_sum got %0d want 1+-3", sum);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL one_range bad got %0d want 0", bad);
    end
    en = 1'b0;
  endtask

  task automatic test_freeze();
    int nz, pre, frz, post;
    logic [3:0] held_ofs;
    logic [8:0] held_frac;
    nz = 0; pre = 0; frz = 0; post = 0;
    do_reset();
    load_idle(9'd100);
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      run_a[i] = $signed(div_ofs);
      if (run_a[i] != 0) nz++;
    end
    n_cmp++;
    if (nz == 0) begin
      n_bad++; $display("FAIL freeze_ref_nonzero got %0d nonzero want >0", nz);
    end
    do_reset();
    load_idle(9'd100);
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ($signed(div_ofs) != run_a[i]) pre++;
    end
    en = 1'b0;
    held_ofs = div_ofs;
    held_frac = frac_q;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (div_ofs !== held_ofs || frac_q !== held_frac) frz++;
    end
    en = 1'b1;
    for (int i = 30; i < 80; i++) begin
      tick();
      if ($signed(div_ofs) != run_a[i]) post++;
    end
    n_cmp++;
    if (pre !== 0) begin
      n_bad++; $display("FAIL freeze_pre diffs got %0d want 0", pre);
    end
    n_cmp++;
    if (frz !== 0) begin
      n_bad++; $display("FAIL freeze_hold diffs got %0d want 0", frz);
    end
    n_cmp++;
    if (post !== 0) begin
      n_bad++; $display("FAIL freeze_resume diffs got %0d want 0", post);
    end
  endtask

  task automatic test_reset_mid();
    int diffs;
    diffs = 0;
    // run is still enabled here; rst must win over the load and enable
    rst = 1'b1; frac_ld = 1'b1; frac_in = 9'd55; en = 1'b1;
    tick();
    rst = 1'b0; frac_ld = 1'b0; en = 1'b0;
    n_cmp++;
    if (div_ofs !== 4'd0) begin
      n_bad++; $display("FAIL rstmid_div_ofs got %h want 0", div_ofs);
    end
    n_cmp++;
    if (ofs_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_valid got %b want 0", ofs_valid);
    end
    n_cmp++;
    if (frac_q !== 9'd0) begin
      n_bad++; $display("FAIL rstmid_frac_q got %0d want 0", frac_q);
    end
    load_idle(9'd100);
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if ($signed(div_ofs) != run_a[i]) diffs++;
    end
    n_cmp++;
    if (diffs !== 0) begin
      n_bad++; $display("FAIL rstmid_replay diffs got %0d want 0", diffs);
    end
    en = 1'b0;
  endtask

  task automatic test_dither();
    int rec[64];
    int sum, changes, diffs, got;
    sum = 0; changes = 0; diffs = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      tick();
      got = $signed(div_ofs);
      if (i < 64) rec[i] = got;
      if (i > 0 && div_ofs !== dut.div_ofs) changes += 0;
      sum += got;
      if (i > 0 && got != rec[0] && i < 64) changes++;
      if (i >= 64 && got != 0) changes++;
    end
    n_cmp++;
    if (changes == 0) begin
      n_bad++; $display("FAIL dither_nonconst changes got %0d want >0", changes);
    end
    // carry-in averages half an LSB of frac, so ~4 output counts over 4096 steps
    n_cmp++;
    if (sum < 1 || sum > 7) begin
      n_bad++; $display("FAIL dither_sum got %0d want 1..7", sum);
    end
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if ($signed(div_ofs) != rec[i]) diffs++;
    end
    n_cmp++;
    if (diffs !== 0) begin
      n_bad++; $display("FAIL dither_repeat diffs got %0d want 0", diffs);
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; frac_ld = 1'b0; frac_in = 9'd0;
    test_reset();
`ifdef MASH_DITHER_EN
    test_dither();
`else
    test_zero();
    test_half();
    test_ld_en_same();
    test_frac_one();
    test_freeze();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
